// File: rtl/fx_pkg.sv
// Shared definitions for the fx register bus: widths, master state
// encoding and the device-select codes carried in the upper address byte.
package fx_pkg;

  localparam int FX_AW = 16;
  localparam int FX_DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } fx_state_e;

  // Device-select codes (fx address bits [15:8]).
  localparam logic [7:0] FX_DEV_SYS = 8'h00;
  localparam logic [7:0] FX_DEV_ADC = 8'h01;
  localparam logic [7:0] FX_DEV_PLL = 8'h02;
  localparam logic [7:0] FX_DEV_LDO = 8'h03;

  // Device-select byte of an fx address.
  function automatic logic [7:0] fx_dev_sel(input logic [FX_AW-1:0] addr);
    return addr[FX_AW-1 -: 8];
  endfunction

endpackage

// File: rtl/fx_master.sv
// fx_master: single-master sequencer for the fx register bus. Turns one
// host command into one fx write or read cycle; read data is sampled from
// the OR-combined slave bus a fixed latency after the read strobe.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready for a host command (cmd_ready high)
// WR      | fx_wr strobe cycle
// RD      | fx_rd strobe cycle
// WAIT    | counting read latency; fx_q sampled when count hits RD_LAT
// GAP     | idle bus cycles between transactions
module fx_master
  import fx_pkg::*;
#(
  parameter int AW     = FX_AW,
  parameter int DW     = FX_DW,
  parameter int RD_LAT = 2,
  parameter int GAP    = 1
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic          fx_wr,
  output logic [AW-1:0] fx_waddr,
  output logic [DW-1:0] fx_data,
  output logic          fx_rd,
  output logic [AW-1:0] fx_raddr,
  input  logic [DW-1:0] fx_q
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $fatal(1, "fx_master: RD_LAT=%0d outside 1..15", RD_LAT);
  end
  if (GAP < 0 || GAP > 7) begin : g_bad_gap
    $fatal(1, "fx_master: GAP=%0d outside 0..7", GAP);
  end

  localparam logic [3:0] LAT_TC = 4'(RD_LAT);
  localparam logic [3:0] GAP_TC = 4'(GAP);

  fx_state_e     state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ready_en_q;
  logic          accept;
  logic          sample;
  logic [AW-1:0] waddr_q, raddr_q;
  logic [DW-1:0] wdata_q, rsp_data_q;
  logic          rsp_valid_q;

  // ready_en_q keeps cmd_ready low until the first clock after reset release.
  assign cmd_ready = (state_q == ST_IDLE) && ready_en_q;
  assign accept    = cmd_valid && cmd_ready;

  // Strobes decode straight from state so a reset drops them asynchronously.
  assign fx_wr     = (state_q == ST_WR);
  assign fx_rd     = (state_q == ST_RD);
  assign busy      = (state_q != ST_IDLE);
  assign fx_waddr  = waddr_q;
  assign fx_data   = wdata_q;
  assign fx_raddr  = raddr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

  // State, shared latency/gap counter and ready enable.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic; the counter is reused for read latency and gap length.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (accept) begin
          state_d = cmd_wr ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        if (GAP_TC == 4'd0) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_GAP;
          cnt_d   = 4'd1;
        end
      end
      ST_RD: begin
        state_d = ST_WAIT;
        cnt_d   = 4'd1;
      end
      ST_WAIT: begin
        if (cnt_q == LAT_TC) begin
          sample = 1'b1;
          if (GAP_TC == 4'd0) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_TC) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Capture the accepted command; bus address/data hold between strobes.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
    end else if (accept) begin
      if (cmd_wr) begin
        waddr_q <= cmd_addr;
        wdata_q <= cmd_wdata;
      end else begin
        raddr_q <= cmd_addr;
      end
    end
  end

  // Sample fx_q at the latency edge and pulse rsp_valid the following cycle.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= sample;
      if (sample) begin
        rsp_data_q <= fx_q;
      end
    end
  end

endmodule

// File: tb/tb_fx_master.sv
// Scoreboard bench for fx_master: u0 uses RD_LAT=2/GAP=1, u1 the corner
// RD_LAT=1/GAP=0. Drivers push expected strobes/responses; per-DUT monitors
// pop and compare whenever a strobe or rsp_valid appears.
module tb_fx_master;
  import fx_pkg::*;

  localparam int LAT0 = 2;
  localparam int GAP0 = 1;
  localparam int LAT1 = 1;
  localparam int GAP1 = 0;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          c;
  } exp_t;

  exp_t wq0[$], rq0[$], sq0[$];
  exp_t wq1[$], rq1[$], sq1[$];
  exp_t em0, em1;

  logic        rst0, cmd_valid0, cmd_ready0, cmd_wr0, rsp_valid0, busy0, fx_wr0, fx_rd0;
  logic [15:0] cmd_addr0, fx_waddr0, fx_raddr0;
  logic [7:0]  cmd_wdata0, rsp_data0, fx_data0, fx_q0;
  logic        rst1, cmd_valid1, cmd_ready1, cmd_wr1, rsp_valid1, busy1, fx_wr1, fx_rd1;
  logic [15:0] cmd_addr1, fx_waddr1, fx_raddr1;
  logic [7:0]  cmd_wdata1, rsp_data1, fx_data1, fx_q1;

  fx_master #(.RD_LAT(LAT0), .GAP(GAP0)) u0 (
    .clk_sys(clk_sys), .rst(rst0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_wr(cmd_wr0), .cmd_addr(cmd_addr0), .cmd_wdata(cmd_wdata0),
    .rsp_valid(rsp_valid0), .rsp_data(rsp_data0), .busy(busy0),
    .fx_wr(fx_wr0), .fx_waddr(fx_waddr0), .fx_data(fx_data0),
    .fx_rd(fx_rd0), .fx_raddr(fx_raddr0), .fx_q(fx_q0)
  );

  fx_master #(.RD_LAT(LAT1), .GAP(GAP1)) u1 (
    .clk_sys(clk_sys), .rst(rst1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_wr(cmd_wr1), .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .busy(busy1),
    .fx_wr(fx_wr1), .fx_waddr(fx_waddr1), .fx_data(fx_data1),
    .fx_rd(fx_rd1), .fx_raddr(fx_raddr1), .fx_q(fx_q1)
  );

  // Slave models: register space written by fx_wr, read data driven only in
  // the cycle RD_LAT after the read strobe. Slave B owns FX_DEV_PLL, slave A
  // every other device; each drives 0 when not selected.
  logic [7:0]  mem0 [65536];
  logic [7:0]  mem1 [65536];
  logic        pv0 [16] = '{default: 1'b0};
  logic        pv1 [16] = '{default: 1'b0};
  logic [15:0] pa0 [16] = '{default: 16'h0};
  logic [15:0] pa1 [16] = '{default: 16'h0};
  logic        inj0 = 1'b0;
  logic        s0, s1;
  logic [15:0] sa0, sa1;
  logic [7:0]  qa0, qb0, qa1, qb1;

  always @(posedge clk_sys) begin
    pv0[0] <= fx_rd0;
    pa0[0] <= fx_raddr0;
    pv1[0] <= fx_rd1;
    pa1[0] <= fx_raddr1;
    for (int i = 1; i < 16; i++) begin
      pv0[i] <= pv0[i-1];
      pa0[i] <= pa0[i-1];
      pv1[i] <= pv1[i-1];
      pa1[i] <= pa1[i-1];
    end
  end

  always @(posedge clk_sys) begin
    if (fx_wr0) mem0[fx_waddr0] = fx_data0;
    if (fx_wr1) mem1[fx_waddr1] = fx_data1;
  end

  assign s0  = pv0[LAT0-1];
  assign sa0 = pa0[LAT0-1];
  assign s1  = pv1[LAT1-1];
  assign sa1 = pa1[LAT1-1];

  always_comb begin
    qa0 = 8'h00;
    qb0 = 8'h00;
    qa1 = 8'h00;
    qb1 = 8'h00;
    if (s0 && sa0[15:8] != FX_DEV_PLL) qa0 = mem0[sa0];
    if (s0 && sa0[15:8] == FX_DEV_PLL) qb0 = mem0[sa0];
    if (s1 && sa1[15:8] != FX_DEV_PLL) qa1 = mem1[sa1];
    if (s1 && sa1[15:8] == FX_DEV_PLL) qb1 = mem1[sa1];
  end

  // Slave A can inject 0x40 onto the OR-bus outside the sample cycle.
  assign fx_q0 = qa0 | qb0 | ((inj0 && !s0) ? 8'h40 : 8'h00);
  assign fx_q1 = qa1 | qb1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor u0.
  always @(negedge clk_sys) begin
    if (fx_wr0 || fx_rd0) chk("u0 strobe overlap", fx_wr0 & fx_rd0, 0);
    if (fx_wr0) begin
      chk("u0 fx_wr expected", wq0.size() > 0, 1);
      if (wq0.size() > 0) begin
        em0 = wq0.pop_front();
        chk("u0 fx_waddr", fx_waddr0, em0.a);
        chk("u0 fx_data", fx_data0, em0.d);
        chk("u0 fx_wr cycle", cyc, em0.c);
      end
    end
    if (fx_rd0) begin
      chk("u0 fx_rd expected", rq0.size() > 0, 1);
      if (rq0.size() > 0) begin
        em0 = rq0.pop_front();
        chk("u0 fx_raddr", fx_raddr0, em0.a);
        chk("u0 fx_rd cycle", cyc, em0.c);
      end
    end
    if (rsp_valid0) begin
      chk("u0 rsp_valid expected", sq0.size() > 0, 1);
      if (sq0.size() > 0) begin
        em0 = sq0.pop_front();
        chk("u0 rsp_data", rsp_data0, em0.d);
        chk("u0 rsp_valid cycle", cyc, em0.c);
      end
    end
  end

  // Monitor u1.
  always @(negedge clk_sys) begin
    if (fx_wr1 || fx_rd1) chk("u1 strobe overlap", fx_wr1 & fx_rd1, 0);
    if (fx_wr1) begin
      chk("u1 fx_wr expected", wq1.size() > 0, 1);
      if (wq1.size() > 0) begin
        em1 = wq1.pop_front();
        chk("u1 fx_waddr", fx_waddr1, em1.a);
        chk("u1 fx_data", fx_data1, em1.d);
        chk("u1 fx_wr cycle", cyc, em1.c);
      end
    end
    if (fx_rd1) begin
      chk("u1 fx_rd expected", rq1.size() > 0, 1);
      if (rq1.size() > 0) begin
        em1 = rq1.pop_front();
        chk("u1 fx_raddr", fx_raddr1, em1.a);
        chk("u1 fx_rd cycle", cyc, em1.c);
      end
    end
    if (rsp_valid1) begin
      chk("u1 rsp_valid expected", sq1.size() > 0, 1);
      if (sq1.size() > 0) begin
        em1 = sq1.pop_front();
        chk("u1 rsp_data", rsp_data1, em1.d);
        chk("u1 rsp_valid cycle", cyc, em1.c);
      end
    end
  end

  function automatic logic rdy(input int d);
    return (d == 0) ? cmd_ready0 : cmd_ready1;
  endfunction

  // Present a command (called at a negedge), wait for accept, push the
  // expected strobe and response, return one negedge after the accept edge
  // with cmd_valid still high.
  task automatic issue(input int d, input logic wr, input logic [15:0] a,
                       input logic [7:0] wd, input logic [7:0] rd_exp, output int acc);
    exp_t e;
    int   n;
    int   lat;
    lat = (d == 0) ? LAT0 : LAT1;
    if (d == 0) begin
      cmd_valid0 = 1'b1; cmd_wr0 = wr; cmd_addr0 = a; cmd_wdata0 = wd;
    end else begin
      cmd_valid1 = 1'b1; cmd_wr1 = wr; cmd_addr1 = a; cmd_wdata1 = wd;
    end
    n = 0;
    while (!rdy(d) && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    chk("cmd accepted in time", n < 50, 1);
    acc = cyc;
    if (n < 50) begin
      e.a = a;
      e.d = wd;
      e.c = cyc + 1;
      if (wr) begin
        if (d == 0) wq0.push_back(e); else wq1.push_back(e);
      end else begin
        if (d == 0) rq0.push_back(e); else rq1.push_back(e);
        e.d = rd_exp;
        e.c = cyc + 1 + lat + 1;
        if (d == 0) sq0.push_back(e); else sq1.push_back(e);
      end
    end
    @(negedge clk_sys);
  endtask

  task automatic drop(input int d);
    if (d == 0) cmd_valid0 = 1'b0; else cmd_valid1 = 1'b0;
  endtask

  task automatic wait_ready(input int d, output int c);
    int n;
    n = 0;
    while (!rdy(d) && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("ready returns in time", n < 100, 1);
    c = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, c, a1, a2, a3;

    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    mem0[16'h0203] = 8'h3C;
    mem0[16'h0205] = 8'h81;
    mem1[16'h0107] = 8'h5A;

    rst0 = 1'b1; cmd_valid0 = 1'b0; cmd_wr0 = 1'b0; cmd_addr0 = '0; cmd_wdata0 = '0;
    rst1 = 1'b1; cmd_valid1 = 1'b0; cmd_wr1 = 1'b0; cmd_addr1 = '0; cmd_wdata1 = '0;

    repeat (3) @(negedge clk_sys);
    chk("u0 reset outputs",
        {cmd_ready0, busy0, fx_wr0, fx_rd0, rsp_valid0, rsp_data0, fx_waddr0, fx_raddr0, fx_data0}, 0);
    chk("u1 reset outputs",
        {cmd_ready1, busy1, fx_wr1, fx_rd1, rsp_valid1, rsp_data1, fx_waddr1, fx_raddr1, fx_data1}, 0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("u0 ready low before first clock", cmd_ready0, 0);
    @(negedge clk_sys);
    chk("u0 ready after reset", cmd_ready0, 1);
    chk("u1 ready after reset", cmd_ready1, 1);

    // Single write: strobe next cycle, no response, ready after 2+GAP.
    issue(0, 1'b1, 16'h0112, 8'hA5, 8'h00, acc);
    drop(0);
    wait_ready(0, c);
    chk("u0 write turnaround", c - acc, 2 + GAP0);

    // Single read from slave B.
    issue(0, 1'b0, 16'h0203, 8'h00, 8'h3C, acc);
    drop(0);
    wait_ready(0, c);
    chk("u0 read turnaround", c - acc, 2 + LAT0 + GAP0);
    chk("u0 rsp_data after read", rsp_data0, 8'h3C);

    // Back-to-back with cmd_valid held: W, R of the written byte, W.
    issue(0, 1'b1, 16'h0010, 8'h01, 8'h00, a1);
    issue(0, 1'b0, 16'h0010, 8'h00, 8'h01, a2);
    issue(0, 1'b1, 16'h0011, 8'hFF, 8'h00, a3);
    drop(0);
    wait_ready(0, c);
    chk("u0 b2b write spacing", a2 - a1, 2 + GAP0);
    chk("u0 b2b read spacing", a3 - a2, 2 + LAT0 + GAP0);
    chk("u0 rsp_data held over write", rsp_data0, 8'h01);

    // OR-bus: slave A injects 0x40 outside the sample edge.
    inj0 = 1'b1;
    issue(0, 1'b0, 16'h0205, 8'h00, 8'h81, acc);
    drop(0);
    wait_ready(0, c);
    repeat (4) @(negedge clk_sys);
    chk("u0 rsp_data ignores injection", rsp_data0, 8'h81);
    inj0 = 1'b0;

    // Reset during WAIT aborts the read with no response.
    issue(0, 1'b0, 16'h0203, 8'h00, 8'h3C, acc);
    drop(0);
    @(negedge clk_sys);
    chk("u0 busy in WAIT", busy0, 1);
    #2;
    rst0 = 1'b1;
    #1;
    sq0.delete();
    chk("u0 abort fx_rd", fx_rd0, 0);
    chk("u0 abort busy", busy0, 0);
    chk("u0 abort rsp_data", rsp_data0, 8'h00);
    repeat (3) @(negedge clk_sys);
    rst0 = 1'b0;
    @(negedge clk_sys);
    chk("u0 ready after abort", cmd_ready0, 1);
    repeat (3) @(negedge clk_sys);
    chk("u0 no rsp after abort", rsp_valid0, 0);
    issue(0, 1'b0, 16'h0203, 8'h00, 8'h3C, acc);
    drop(0);
    wait_ready(0, c);
    chk("u0 rsp_data after recovery", rsp_data0, 8'h3C);

    // Corner parameters RD_LAT=1, GAP=0.
    issue(1, 1'b0, 16'h0107, 8'h00, 8'h5A, acc);
    drop(1);
    wait_ready(1, c);
    chk("u1 read turnaround", c - acc, 2 + LAT1 + GAP1);
    issue(1, 1'b1, 16'h0101, 8'h11, 8'h00, a1);
    issue(1, 1'b1, 16'h0102, 8'h22, 8'h00, a2);
    issue(1, 1'b1, 16'h0103, 8'h33, 8'h00, a3);
    drop(1);
    wait_ready(1, c);
    chk("u1 write spacing 1", a2 - a1, 2);
    chk("u1 write spacing 2", a3 - a2, 2);
    chk("u1 rsp_data held", rsp_data1, 8'h5A);

    repeat (10) @(negedge clk_sys);
    chk("u0 scoreboard drained", wq0.size() + rq0.size() + sq0.size(), 0);
    chk("u1 scoreboard drained", wq1.size() + rq1.size() + sq1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
